// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular TX byte buffer with two write ports, edge-triggered pop and optional CR->CRLF expansion.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   byte_in/in_valid         primary write port (wins arbitration)
//   char_in/char_valid       secondary write port (dropped when primary writes)
//   byte_out                 registered head byte (LF while inserting)
//   out_advance              transmitter busy level; its rising edge consumes byte_out
//   out_ready                registered: byte_out valid and transmitter idle
//   full, level              registered occupancy flags
//   drop_count               saturating count of discarded write cycles
module uart_tx_fifo #(
    parameter int                DATA_W      = 8,
    parameter int                DEPTH_LOG2  = 10,
    parameter bit                CRLF_EXPAND = 1'b1,
    parameter logic [DATA_W-1:0] CR_CODE     = 'h0D,
    parameter logic [DATA_W-1:0] LF_CODE     = 'h0A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     byte_in,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     char_in,
    input  logic                  char_valid,
    output logic [DATA_W-1:0]     byte_out,
    input  logic                  out_advance,
    output logic                  out_ready,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           drop_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic {SEND, INSERT_LF} state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [15:0]           drop_q;
    logic                  adv_q, full_q, ready_q, ready_d;
    logic [DATA_W-1:0]     byte_q, byte_d, head;
    state_t                state_q, state_d;
    logic                  pop, has_room, wr_ok, drop_ev, adv_rd;

    always_comb begin
        pop      = out_advance && !adv_q;
        has_room = level_q != DEPTH_L;
        wr_ok    = (in_valid || char_valid) && has_room;
        // one drop per cycle, whether the loser of arbitration, the winner on a full buffer, or both
        drop_ev  = (in_valid && char_valid) || ((in_valid || char_valid) && !has_room);
        head     = mem[rd_ptr_q];
        adv_rd   = pop && state_q == SEND && level_q != '0;
        level_d  = (wr_ok && !adv_rd) ? level_q + 1'b1 :
                   (adv_rd && !wr_ok) ? level_q - 1'b1 : level_q;
        state_d  = state_q == INSERT_LF ? (pop ? SEND : INSERT_LF) :
                   (adv_rd && CRLF_EXPAND && head == CR_CODE) ? INSERT_LF : SEND;
        byte_d   = state_q == INSERT_LF ? LF_CODE : head;
        ready_d  = (state_q == INSERT_LF || level_q != '0) && !out_advance;
    end

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= in_valid ? byte_in : char_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            adv_q    <= 1'b0;
            full_q   <= 1'b0;
            ready_q  <= 1'b0;
            byte_q   <= '0;
            state_q  <= SEND;
        end else begin
            adv_q   <= out_advance;
            level_q <= level_d;
            full_q  <= level_d == DEPTH_L;
            ready_q <= ready_d;
            byte_q  <= byte_d;
            state_q <= state_d;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (adv_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop_ev && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
        end
    end

    assign byte_out   = byte_q;
    assign out_ready  = ready_q;
    assign full       = full_q;
    assign level      = level_q;
    assign drop_count = drop_q;
endmodule
